// File: rtl/dm_wr_seq.sv
// rtl/dm_wr_seq.sv - DDR3 write data-mask sequencer with mask FIFO and DM output delay update
module dm_wr_seq #(
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       wr_start,
  input  logic [5:0] wr_bursts,
  output logic       wr_busy,
  input  logic       mask_valid,
  input  logic [7:0] mask_data,
  output logic       mask_ready,
  output logic       underrun,
  input  logic       err_clr,
  output logic [3:0] din,
  output logic [3:0] tin,
  input  logic       dly_wr,
  input  logic [7:0] dly_in,
  output logic [7:0] dly_data,
  output logic       set_odelay,
  output logic       ld_odelay,
  output logic       dly_busy
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BURST_LO, S_BURST_HI, S_POST} state_t;
  typedef enum logic [1:0] {D_IDLE, D_SET, D_LD} dstate_t;

  state_t               state, state_nxt;
  dstate_t              dst, dst_nxt;
  logic [5:0]           cnt, cnt_nxt;
  logic [7:0]           cur_byte, byte_nxt;
  logic                 cur_under, under_nxt;
  logic [3:0]           din_nxt, tin_nxt;
  logic                 busy_nxt, underrun_nxt;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [FIFO_LOG2:0]   count, count_pop, count_nxt;
  logic                 push, pop, empty_nxt;
  logic [7:0]           head_nxt;
  logic                 pend, pend_nxt, set_nxt, ld_nxt, dbusy_nxt;
  logic [7:0]           val, val_nxt, dly_data_nxt;
  logic                 start_ok, dly_start;

  // Depth is a power of two, so the count MSB alone marks full.
  assign mask_ready = ~count[FIFO_LOG2];
  assign push       = mask_valid && mask_ready;
  assign pop        = (state == S_BURST_HI) && !cur_under;
  assign count_pop  = count - (FIFO_LOG2+1)'(pop);
  assign count_nxt  = count_pop + (FIFO_LOG2+1)'(push);
  assign rd_nxt     = rd_ptr + FIFO_LOG2'(pop);
  assign empty_nxt  = (count_nxt == '0);
  // Head as seen after this edge; forwards a byte pushed into a just-drained FIFO.
  assign head_nxt   = (count_pop == '0) ? mask_data : mem[rd_nxt];

  assign start_ok  = (state == S_IDLE) && wr_start && (wr_bursts != 6'd0) && (dst == D_IDLE);
  assign dly_start = (state == S_IDLE) && !wr_start && pend && (dst == D_IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    byte_nxt     = cur_byte;
    under_nxt    = cur_under;
    underrun_nxt = underrun & ~err_clr;
    din_nxt      = 4'h0;
    tin_nxt      = 4'h0;
    case (state)
      S_IDLE: if (start_ok) begin
        state_nxt = S_PRE;
        cnt_nxt   = wr_bursts;
      end
      S_PRE:      state_nxt = S_BURST_LO;
      S_BURST_LO: state_nxt = S_BURST_HI;
      S_BURST_HI: begin
        cnt_nxt   = cnt - 6'd1;
        state_nxt = (cnt == 6'd1) ? S_POST : S_BURST_LO;
      end
      S_POST:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_IDLE: tin_nxt = 4'hF;
      S_BURST_LO: begin
        byte_nxt  = head_nxt;
        under_nxt = empty_nxt;
        din_nxt   = empty_nxt ? 4'hF : head_nxt[3:0];
        if (empty_nxt) underrun_nxt = 1'b1;
      end
      S_BURST_HI: din_nxt = cur_under ? 4'hF : cur_byte[7:4];
      default: ;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_comb begin
    dst_nxt      = dst;
    set_nxt      = 1'b0;
    ld_nxt       = 1'b0;
    dly_data_nxt = dly_data;
    pend_nxt     = pend;
    val_nxt      = val;
    case (dst)
      D_IDLE: if (dly_start) begin
        dst_nxt      = D_SET;
        set_nxt      = 1'b1;
        dly_data_nxt = val;
        pend_nxt     = 1'b0;
      end
      D_SET: begin
        dst_nxt = D_LD;
        ld_nxt  = 1'b1;
      end
      default: dst_nxt = D_IDLE;
    endcase
    if (dly_wr) begin
      pend_nxt = 1'b1;
      val_nxt  = dly_in;
    end
    dbusy_nxt = pend_nxt || (dst_nxt != D_IDLE);
  end

  always_ff @(posedge clk_div) begin
    if (push) mem[wr_ptr] <= mask_data;
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      cur_byte   <= 8'h00;
      cur_under  <= 1'b0;
      din        <= 4'h0;
      tin        <= 4'hF;
      wr_busy    <= 1'b0;
      underrun   <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      dst        <= D_IDLE;
      pend       <= 1'b0;
      val        <= 8'h00;
      dly_data   <= 8'h00;
      set_odelay <= 1'b0;
      ld_odelay  <= 1'b0;
      dly_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_byte   <= byte_nxt;
      cur_under  <= under_nxt;
      din        <= din_nxt;
      tin        <= tin_nxt;
      wr_busy    <= busy_nxt;
      underrun   <= underrun_nxt;
      count      <= count_nxt;
      rd_ptr     <= rd_nxt;
      wr_ptr     <= wr_ptr + FIFO_LOG2'(push);
      dst        <= dst_nxt;
      pend       <= pend_nxt;
      val        <= val_nxt;
      dly_data   <= dly_data_nxt;
      set_odelay <= set_nxt;
      ld_odelay  <= ld_nxt;
      dly_busy   <= dbusy_nxt;
    end
  end

endmodule

// File: tb/tb_dm_wr_seq.sv
// tb/tb_dm_wr_seq.sv - directed self-checking bench for dm_wr_seq
module tb_dm_wr_seq;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_start = 1'b0;
  logic [5:0] wr_bursts = 6'd0;
  logic       wr_busy;
  logic       mask_valid = 1'b0;
  logic [7:0] mask_data = 8'h00;
  logic       mask_ready;
  logic       underrun;
  logic       err_clr = 1'b0;
  logic [3:0] din;
  logic [3:0] tin;
  logic       dly_wr = 1'b0;
  logic [7:0] dly_in = 8'h00;
  logic [7:0] dly_data;
  logic       set_odelay;
  logic       ld_odelay;
  logic       dly_busy;

  int checks = 0;
  int errors = 0;

  dm_wr_seq #(.FIFO_LOG2(2)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .wr_start(wr_start), .wr_bursts(wr_bursts),
    .wr_busy(wr_busy), .mask_valid(mask_valid), .mask_data(mask_data),
    .mask_ready(mask_ready), .underrun(underrun), .err_clr(err_clr), .din(din),
    .tin(tin), .dly_wr(dly_wr), .dly_in(dly_in), .dly_data(dly_data),
    .set_odelay(set_odelay), .ld_odelay(ld_odelay), .dly_busy(dly_busy)
  );

  always #5 clk_div = ~clk_div;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    mask_valid = 1'b1;
    mask_data  = b;
    tick();
    mask_valid = 1'b0;
  endtask

  // nibs holds the expected burst nibbles, first output nibble in bits [3:0].
  task automatic do_write(input logic [5:0] b, input logic [31:0] nibs, input string tag);
    wr_start  = 1'b1;
    wr_bursts = b;
    tick();
    wr_start = 1'b0;
    check({tag, "_pre_din"}, din, 4'h0);
    check({tag, "_pre_tin"}, tin, 4'h0);
    check({tag, "_pre_busy"}, wr_busy, 1'b1);
    for (int i = 0; i < 2 * int'(b); i++) begin
      tick();
      check({tag, "_burst_din"}, din, nibs[4*i +: 4]);
      check({tag, "_burst_tin"}, tin, 4'h0);
    end
    tick();
    check({tag, "_post_din"}, din, 4'h0);
    check({tag, "_post_tin"}, tin, 4'h0);
    tick();
    check({tag, "_idle_tin"}, tin, 4'hF);
    check({tag, "_idle_din"}, din, 4'h0);
    check({tag, "_idle_busy"}, wr_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_din", din, 4'h0);
    check("rst_tin", tin, 4'hF);
    check("rst_busy", wr_busy, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_set", set_odelay, 1'b0);
    check("rst_ld", ld_odelay, 1'b0);
    check("rst_dly_data", dly_data, 8'h00);
    check("rst_dly_busy", dly_busy, 1'b0);
    check("rst_ready", mask_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Two-burst write of A5, 3C
    push_byte(8'hA5);
    push_byte(8'h3C);
    do_write(6'd2, 32'h0000_3CA5, "w2");
    check("w2_underrun", underrun, 1'b0);

    // Empty FIFO single burst underruns
    do_write(6'd1, 32'h0000_00FF, "under");
    check("under_flag", underrun, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("under_clr", underrun, 1'b0);

    // Fill to full, fifth byte dropped
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("ready_3", mask_ready, 1'b1);
    push_byte(8'h44);
    check("ready_full", mask_ready, 1'b0);
    push_byte(8'h55);
    check("ready_full2", mask_ready, 1'b0);
    do_write(6'd1, 32'h0000_0011, "pop1");
    check("ready_after_pop", mask_ready, 1'b1);
    do_write(6'd3, 32'h0044_3322, "drain");
    check("drain_underrun", underrun, 1'b0);
    do_write(6'd1, 32'h0000_00FF, "no55");
    check("no55_underrun", underrun, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Delay update requested mid-write, applied after return to IDLE
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wr_start  = 1'b1;
    wr_bursts = 6'd3;
    tick();
    wr_start = 1'b0;
    dly_wr   = 1'b1;
    dly_in   = 8'h5B;
    check("dly_busy_before", dly_busy, 1'b0);
    tick();
    dly_wr = 1'b0;
    check("dly_busy_after_wr", dly_busy, 1'b1);
    check("dly_burst_din", din, 4'h1);
    for (int c = 3; c <= 8; c++) begin
      tick();
      check("dly_no_set_in_write", set_odelay, 1'b0);
    end
    tick();
    check("dly_idle_busy", wr_busy, 1'b0);
    check("dly_idle_set", set_odelay, 1'b0);
    tick();
    check("dly_set", set_odelay, 1'b1);
    check("dly_data", dly_data, 8'h5B);
    check("dly_ld_early", ld_odelay, 1'b0);
    check("dly_busy_set", dly_busy, 1'b1);
    wr_start  = 1'b1;
    wr_bursts = 6'd1;
    tick();
    check("dly_ld", ld_odelay, 1'b1);
    check("dly_set_off", set_odelay, 1'b0);
    check("dly_start_ign1", wr_busy, 1'b0);
    check("dly_busy_ld", dly_busy, 1'b1);
    tick();
    wr_start = 1'b0;
    check("dly_ld_off", ld_odelay, 1'b0);
    check("dly_start_ign2", wr_busy, 1'b0);
    tick();
    check("dly_busy_done", dly_busy, 1'b0);
    check("dly_data_hold", dly_data, 8'h5B);
    check("dly_tin_idle", tin, 4'hF);

    // Reset in BURST_HI tristates without a clock edge
    push_byte(8'hC3);
    wr_start  = 1'b1;
    wr_bursts = 6'd2;
    tick();
    wr_start = 1'b0;
    tick();
    check("rb_lo_din", din, 4'h3);
    tick();
    check("rb_hi_din", din, 4'hC);
    check("rb_hi_tin", tin, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rb_async_tin", tin, 4'hF);
    check("rb_async_din", din, 4'h0);
    check("rb_async_busy", wr_busy, 1'b0);
    check("rb_async_ready", mask_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    wr_start  = 1'b1;
    wr_bursts = 6'd0;
    tick();
    wr_start = 1'b0;
    check("zero_busy", wr_busy, 1'b0);
    check("zero_tin", tin, 4'hF);
    tick();
    check("zero_busy2", wr_busy, 1'b0);

    // Underrun set wins over simultaneous err_clr; FIFO was cleared by reset
    wr_start  = 1'b1;
    wr_bursts = 6'd1;
    tick();
    wr_start = 1'b0;
    err_clr  = 1'b1;
    tick();
    check("prio_din", din, 4'hF);
    check("prio_underrun", underrun, 1'b1);
    tick();
    err_clr = 1'b0;
    check("prio_cleared", underrun, 1'b0);
    tick();
    tick();
    check("prio_idle_tin", tin, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
